// File: rtl/pc_gen.sv
// Fetch program counter: multi-slot fetch groups, exception/ERET redirects
// and a one-entry buffer that holds a branch target across a fetch stall.
module pc_gen #(
   parameter int                ADDR_W       = 32,
   parameter int                FETCH_WIDTH  = 2,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_0380)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   exc_taken_i,
   input  logic                   eret_i,
   input  logic [ADDR_W-1:0]      epc_i,
   input  logic                   branch_taken_i,
   input  logic [ADDR_W-1:0]      branch_address_i,
   output logic [ADDR_W-1:0]      pc_address_o,
   output logic [FETCH_WIDTH-1:0] fetch_valid_o,
   output logic                   alignment_error_o,
   output logic                   redirect_pending_o
);

   localparam int OFF_W = $clog2(FETCH_WIDTH) + 2;
   localparam int IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4 * FETCH_WIDTH);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] pend_addr;
   logic [ADDR_W-1:0] pend_addr_next;
   logic              pend_valid;
   logic              pend_valid_next;
   logic [ADDR_W-1:0] group_base;
   logic [IDX_W-1:0]  word_idx;
   logic              misaligned;

   assign group_base = {pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign misaligned = |pc[1:0];

   generate
      if (FETCH_WIDTH > 1) begin : g_idx
         assign word_idx = pc[OFF_W-1:2];
      end else begin : g_idx_single
         assign word_idx = '0;
      end
   endgenerate

   // Slots before the entry word of the group are not part of this fetch.
   always_comb begin
      fetch_valid_o = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         fetch_valid_o[i] = !misaligned && (IDX_W'(i) >= word_idx);
      end
   end

   always_comb begin
      pc_next         = pc;
      pend_valid_next = pend_valid;
      pend_addr_next  = pend_addr;
      if (exc_taken_i) begin
         pc_next         = EXC_VECTOR;
         pend_valid_next = 1'b0;
      end else if (eret_i) begin
         pc_next         = epc_i;
         pend_valid_next = 1'b0;
      end else if (stall_i) begin
         // Newest branch during a stall replaces any older held target.
         if (branch_taken_i) begin
            pend_valid_next = 1'b1;
            pend_addr_next  = branch_address_i;
         end
      end else if (branch_taken_i) begin
         pc_next         = branch_address_i;
         pend_valid_next = 1'b0;
      end else if (pend_valid) begin
         pc_next         = pend_addr;
         pend_valid_next = 1'b0;
      end else if (!misaligned) begin
         pc_next = group_base + STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_VECTOR;
         pend_valid <= 1'b0;
         pend_addr  <= '0;
      end else begin
         pc         <= pc_next;
         pend_valid <= pend_valid_next;
         pend_addr  <= pend_addr_next;
      end
   end

   assign pc_address_o       = pc;
   assign alignment_error_o  = misaligned;
   assign redirect_pending_o = pend_valid;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage of the core; successor to the single-issue PC.
- Supports multi-instruction fetch groups, configurable reset and exception vectors, and exception and ERET redirects.
- A branch redirect that arrives while fetch is stalled is held in a one-entry pending buffer instead of being lost.
- Drives the I-cache fetch address and a per-slot valid mask to the decode stage.

Parameters:
- ADDR_W, 32, width of the PC in bits.
- FETCH_WIDTH, 2, instructions per fetch group; legal values 1, 2, 4.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0380, PC value loaded on an exception redirect.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  fetch stall; PC holds unless an exception or ERET redirect is present.
- exc_taken_i  in  1  exception redirect to EXC_VECTOR.
- eret_i  in  1  return-from-exception redirect to epc_i.
- epc_i  in  ADDR_W  ERET target address.
- branch_taken_i  in  1  branch redirect request.
- branch_address_i  in  ADDR_W  branch target address.
- pc_address_o  out  ADDR_W  current fetch address.
- fetch_valid_o  out  FETCH_WIDTH  slot-valid mask for the current group.
- alignment_error_o  out  1  current PC is not word aligned.
- redirect_pending_o  out  1  a branch target is held in the pending buffer.

Behaviour:
- Reset: pc = RESET_VECTOR; pending valid = 0; pending address = 0; redirect_pending_o = 0.
  - Outputs after reset follow from pc: fetch_valid_o reflects RESET_VECTOR alignment; alignment_error_o = |RESET_VECTOR[1:0].
  - Reset asserted mid-stall or with a pending branch discards the pending entry.
- All outputs are combinational from registered state: pc_address_o = pc; redirect_pending_o = pending valid.
- Group base = pc with the low log2(FETCH_WIDTH)+2 bits cleared. Word index w = pc[log2(FETCH_WIDTH)+1:2], or 0 when FETCH_WIDTH = 1.
- fetch_valid_o[i] = 1 iff i >= w and alignment_error_o = 0. Bit i corresponds to address group base + 4*i.
- alignment_error_o = |pc[1:0]. While this is set, sequential advance is suppressed and pc holds; only a redirect (exception, ERET, branch or pending) moves pc.
- Next-state priority, highest first, evaluated every cycle when rst = 0:
  1. exc_taken_i: pc <= EXC_VECTOR; pending cleared. Ignores stall_i.
  2. eret_i: pc <= epc_i; pending cleared. Ignores stall_i.
  3. stall_i = 1: pc holds. If branch_taken_i, the pending buffer captures branch_address_i and its valid bit is set; a newer branch overwrites an older pending entry.
  4. branch_taken_i (not stalled): pc <= branch_address_i; pending cleared. A live branch wins over a stale pending entry.
  5. Pending valid (not stalled): pc <= pending address; pending cleared.
  6. Not misaligned: pc <= group base + 4*FETCH_WIDTH.
  7. Otherwise: pc holds.
- Arithmetic is modulo 2^ADDR_W; a sequential advance past the top of the address space wraps to 0.
- Redirect latency is 1 cycle: a redirect sampled at edge N is visible on pc_address_o after edge N.
- Targets are not realigned. A branch to a non-group-aligned address produces a partial valid mask; a misaligned target raises alignment_error_o on the next cycle.
- Simultaneous exc_taken_i and eret_i: exception wins.

Test Plan:
- Reset then 3 unstalled cycles, FETCH_WIDTH=2 -> pc 0x0, 0x8, 0x10, 0x18; fetch_valid_o = 2'b11 throughout.
- Branch to 0x104 with FETCH_WIDTH=2 -> next pc 0x104, fetch_valid_o = 2'b10; following pc 0x108, mask 2'b11.
- stall_i=1 for 3 cycles with branch_taken_i pulsed (0x200) in cycle 1 and again (0x300) in cycle 2 -> pc holds and redirect_pending_o=1; after stall drops, pc = 0x300 and pending clears.
- exc_taken_i together with stall_i=1 and a pending entry -> pc = 0x380, pending cleared; eret_i with epc_i=0x40 -> pc = 0x40.
- Branch to 0x102 -> alignment_error_o=1, fetch_valid_o=0, pc holds at 0x102 over 3 cycles; a later exc_taken_i -> pc 0x380, error clears.
- pc = 0xFFFF_FFF8 with FETCH_WIDTH=2, unstalled -> next pc 0x0000_0000; rst asserted during a stall with pending set -> pc = RESET_VECTOR, redirect_pending_o = 0.
